// File: rtl/md_unit_ctrl.sv
// Multiply/divide sequencer for the E stage: latches one MDU op per start pulse,
// counts its latency, owns HI/LO and requests a D-stage stall while busy.
module md_unit_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        md_start,
  input  logic [2:0]  md_op,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  input  logic        d_is_md,
  output logic        busy,
  output logic        md_stall,
  output logic        md_done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = ($clog2(MAX_CYCLES + 1) > 4) ? $clog2(MAX_CYCLES + 1) : 4;
  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state_r;
  logic [CNT_W-1:0] cnt_r;
  logic [1:0]       op_r;
  logic [31:0]      a_r;
  logic [31:0]      b_r;
  logic [31:0]      hi_r;
  logic [31:0]      lo_r;
  logic             done_r;
  logic [63:0]      result_s;

  // Low 64 bits of the product of the 64-bit extended operands equal the true product.
  function automatic logic [63:0] mul_fn(input logic [31:0] a, input logic [31:0] b,
                                         input logic is_signed);
    logic [63:0] ext_a;
    logic [63:0] ext_b;
    ext_a = is_signed ? {{32{a[31]}}, a} : {32'd0, a};
    ext_b = is_signed ? {{32{b[31]}}, b} : {32'd0, b};
    return ext_a * ext_b;
  endfunction

  // Sign-magnitude divide: quotient truncates to zero, remainder takes the dividend's sign.
  function automatic logic [63:0] div_fn(input logic [31:0] a, input logic [31:0] b,
                                         input logic is_signed);
    logic        neg_a;
    logic        neg_b;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [31:0] uq;
    logic [31:0] ur;
    neg_a = is_signed & a[31];
    neg_b = is_signed & b[31];
    mag_a = neg_a ? (32'd0 - a) : a;
    mag_b = neg_b ? (32'd0 - b) : b;
    if (mag_b == 32'd0) mag_b = 32'd1;
    uq = mag_a / mag_b;
    ur = mag_a % mag_b;
    return {(neg_a ? (32'd0 - ur) : ur), ((neg_a ^ neg_b) ? (32'd0 - uq) : uq)};
  endfunction

  // Result selection from the latched operands; a zero divisor keeps HI/LO as they are.
  always_comb begin
    result_s = {hi_r, lo_r};
    case (op_r)
      2'd0: result_s = mul_fn(a_r, b_r, 1'b1);
      2'd1: result_s = mul_fn(a_r, b_r, 1'b0);
      2'd2: if (b_r != 32'd0) result_s = div_fn(a_r, b_r, 1'b1); else result_s = {hi_r, lo_r};
      2'd3: if (b_r != 32'd0) result_s = div_fn(a_r, b_r, 1'b0); else result_s = {hi_r, lo_r};
      default: result_s = {hi_r, lo_r};
    endcase
  end

  // Sequencer FSM, latency counter and HI/LO ownership.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
      cnt_r   <= CNT_ZERO;
      op_r    <= 2'd0;
      a_r     <= 32'd0;
      b_r     <= 32'd0;
      hi_r    <= 32'd0;
      lo_r    <= 32'd0;
      done_r  <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (md_start) begin
            case (md_op)
              3'd0, 3'd1: begin
                op_r    <= md_op[1:0];
                a_r     <= op_a;
                b_r     <= op_b;
                cnt_r   <= MULT_LOAD;
                state_r <= RUN;
              end
              3'd2, 3'd3: begin
                op_r    <= md_op[1:0];
                a_r     <= op_a;
                b_r     <= op_b;
                cnt_r   <= DIV_LOAD;
                state_r <= RUN;
              end
              3'd4:    hi_r <= op_a;
              3'd5:    lo_r <= op_a;
              default: ;
            endcase
          end
        end
        RUN: begin
          if (cnt_r == CNT_ONE) begin
            hi_r    <= result_s[63:32];
            lo_r    <= result_s[31:0];
            done_r  <= 1'b1;
            cnt_r   <= CNT_ZERO;
            state_r <= IDLE;
          end else begin
            cnt_r <= cnt_r - CNT_ONE;
          end
        end
        default: begin
          state_r <= IDLE;
          cnt_r   <= CNT_ZERO;
        end
      endcase
    end
  end

  assign busy     = (state_r == RUN);
  assign md_done  = done_r;
  assign hi       = hi_r;
  assign lo       = lo_r;
  // The stall must already be raised in the cycle the op is issued, hence combinational.
  assign md_stall = d_is_md & (busy | (md_start & (md_op <= 3'd3)));

endmodule

// File: tb/tb_md_unit_ctrl.sv
// Self-checking bench for md_unit_ctrl: directed scenarios plus randomized ops
// compared against a 64-bit arithmetic reference model of HI/LO.
module tb_md_unit_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        md_start;
  logic [2:0]  md_op;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        d_is_md;
  logic        busy;
  logic        md_stall;
  logic        md_done;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks   = 0;
  int failures = 0;
  logic [31:0] hi_m = 32'd0;
  logic [31:0] lo_m = 32'd0;

  md_unit_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .md_start(md_start), .md_op(md_op),
    .op_a(op_a), .op_b(op_b), .d_is_md(d_is_md), .busy(busy),
    .md_stall(md_stall), .md_done(md_done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic int lat(input logic [2:0] op);
    if (op <= 3'd1) return 5;
    if (op <= 3'd3) return 10;
    return 0;
  endfunction

  // Reference: HI/LO after an op, from plain 64-bit arithmetic.
  task automatic model_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint      sa;
    longint      sb;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      3'd0: begin p = 64'(sa * sb); hi_m = p[63:32]; lo_m = p[31:0]; end
      3'd1: begin p = {32'd0, a} * {32'd0, b}; hi_m = p[63:32]; lo_m = p[31:0]; end
      3'd2: if (b != 32'd0) begin lo_m = 32'(sa / sb); hi_m = 32'(sa % sb); end
      3'd3: if (b != 32'd0) begin lo_m = a / b; hi_m = a % b; end
      3'd4: hi_m = a;
      3'd5: lo_m = a;
      default: ;
    endcase
  endtask

  // Issues one op and follows it until busy drops; optionally pokes md_start mid-run.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input bit intrude, output int cycles, output bit done_end,
                        output bit glitch);
    logic [31:0] hi0;
    logic [31:0] lo0;
    hi0 = hi;
    lo0 = lo;
    glitch = 1'b0;
    md_start = 1'b1; md_op = op; op_a = a; op_b = b;
    tick;
    md_start = 1'b0; md_op = 3'($urandom_range(0, 7)); op_a = $urandom; op_b = $urandom;
    model_op(op, a, b);
    cycles = 0;
    while (busy === 1'b1 && cycles < 40) begin
      cycles++;
      if (md_done !== 1'b0 || hi !== hi0 || lo !== lo0) glitch = 1'b1;
      if (intrude && cycles == 2) begin
        md_start = 1'b1; md_op = 3'($urandom_range(0, 5)); op_a = $urandom; op_b = $urandom;
      end else begin
        md_start = 1'b0;
      end
      tick;
    end
    md_start = 1'b0;
    done_end = md_done;
  endtask

  task automatic test_reset;
    reset = 1'b1; md_start = 1'b0; md_op = 3'd0; op_a = 32'd0; op_b = 32'd0; d_is_md = 1'b0;
    tick; tick;
    checks++;
    if (busy !== 1'b0 || md_done !== 1'b0 || hi !== 32'd0 || lo !== 32'd0 || md_stall !== 1'b0) begin
      failures++;
      $display("FAIL reset: busy=%b done=%b hi=%h lo=%h stall=%b, required 0/0/0/0/0",
               busy, md_done, hi, lo, md_stall);
    end
    reset = 1'b0;
    hi_m = 32'd0; lo_m = 32'd0;
  endtask

  task automatic test_mt;
    int cyc; bit de; bit gl;
    run_op(3'd5, 32'h0000ABCD, 32'd0, 1'b0, cyc, de, gl);
    checks++;
    if (lo !== 32'h0000ABCD || busy !== 1'b0 || cyc != 0 || de !== 1'b0) begin
      failures++;
      $display("FAIL mtlo: lo=%h busy=%b cycles=%0d done=%b, required 0000abcd/0/0/0", lo, busy, cyc, de);
    end
    run_op(3'd4, 32'h00001234, 32'd0, 1'b0, cyc, de, gl);
    checks++;
    if (hi !== 32'h00001234 || lo !== 32'h0000ABCD || cyc != 0) begin
      failures++;
      $display("FAIL mthi: hi=%h lo=%h cycles=%0d, required 00001234/0000abcd/0", hi, lo, cyc);
    end
    run_op(3'd6, 32'hDEADBEEF, 32'h1, 1'b0, cyc, de, gl);
    run_op(3'd7, 32'hCAFEF00D, 32'h2, 1'b0, cyc, de, gl);
    checks++;
    if (hi !== 32'h00001234 || lo !== 32'h0000ABCD || cyc != 0 || de !== 1'b0) begin
      failures++;
      $display("FAIL noop: hi=%h lo=%h cycles=%0d done=%b, required 00001234/0000abcd/0/0", hi, lo, cyc, de);
    end
  endtask

  task automatic test_mult;
    int cyc; bit de; bit gl;
    run_op(3'd0, 32'hFFFFFFFD, 32'd5, 1'b0, cyc, de, gl);
    checks++;
    if (cyc != 5 || de !== 1'b1 || gl || hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFF1) begin
      failures++;
      $display("FAIL mult: cycles=%0d done=%b glitch=%b hi=%h lo=%h, required 5/1/0/ffffffff/fffffff1",
               cyc, de, gl, hi, lo);
    end
    tick;
    checks++;
    if (md_done !== 1'b0) begin
      failures++;
      $display("FAIL mult_done_pulse: md_done=%b one cycle later, required 0", md_done);
    end
  endtask

  task automatic test_div;
    int cyc; bit de; bit gl;
    run_op(3'd2, 32'd7, 32'hFFFFFFFE, 1'b0, cyc, de, gl);
    checks++;
    if (cyc != 10 || de !== 1'b1 || gl || lo !== 32'hFFFFFFFD || hi !== 32'd1) begin
      failures++;
      $display("FAIL div: cycles=%0d done=%b glitch=%b hi=%h lo=%h, required 10/1/0/00000001/fffffffd",
               cyc, de, gl, hi, lo);
    end
    run_op(3'd3, 32'd7, 32'hFFFFFFFE, 1'b0, cyc, de, gl);
    checks++;
    if (cyc != 10 || de !== 1'b1 || lo !== 32'd0 || hi !== 32'd7) begin
      failures++;
      $display("FAIL divu: cycles=%0d done=%b hi=%h lo=%h, required 10/1/00000007/00000000", cyc, de, hi, lo);
    end
  endtask

  task automatic test_div_zero;
    int cyc; bit de; bit gl;
    run_op(3'd4, 32'h11, 32'd0, 1'b0, cyc, de, gl);
    run_op(3'd5, 32'h22, 32'd0, 1'b0, cyc, de, gl);
    run_op(3'd3, 32'h1234_5678, 32'd0, 1'b0, cyc, de, gl);
    checks++;
    if (cyc != 10 || de !== 1'b1 || gl || hi !== 32'h11 || lo !== 32'h22) begin
      failures++;
      $display("FAIL divzero: cycles=%0d done=%b glitch=%b hi=%h lo=%h, required 10/1/0/00000011/00000022",
               cyc, de, gl, hi, lo);
    end
  endtask

  task automatic test_overflow;
    int cyc; bit de; bit gl;
    run_op(3'd2, 32'h80000000, 32'hFFFFFFFF, 1'b1, cyc, de, gl);
    checks++;
    if (cyc != 10 || de !== 1'b1 || gl || lo !== 32'h80000000 || hi !== 32'd0) begin
      failures++;
      $display("FAIL overflow_intrude: cycles=%0d done=%b glitch=%b hi=%h lo=%h, required 10/1/0/00000000/80000000",
               cyc, de, gl, hi, lo);
    end
  endtask

  task automatic test_stall;
    int n; bit bad;
    d_is_md = 1'b1; md_start = 1'b1; md_op = 3'd0; op_a = 32'd3; op_b = 32'd4;
    #1;
    checks++;
    if (md_stall !== 1'b1) begin
      failures++;
      $display("FAIL stall_start: md_stall=%b, required 1", md_stall);
    end
    model_op(3'd0, 32'd3, 32'd4);
    tick;
    md_start = 1'b0;
    n = 0; bad = 1'b0;
    while (busy === 1'b1 && n < 40) begin
      n++;
      if (md_stall !== 1'b1) bad = 1'b1;
      tick;
    end
    checks++;
    if (bad || n != 5 || md_stall !== 1'b0 || lo !== 32'd12) begin
      failures++;
      $display("FAIL stall_busy: gap=%b cycles=%0d stall_after=%b lo=%h, required 0/5/0/0000000c",
               bad, n, md_stall, lo);
    end
    md_start = 1'b1; md_op = 3'd4;
    #1;
    checks++;
    if (md_stall !== 1'b0) begin
      failures++;
      $display("FAIL stall_mt: md_stall=%b for MTHI issue, required 0", md_stall);
    end
    md_start = 1'b0;
    tick;
    d_is_md = 1'b0; md_start = 1'b1; md_op = 3'd2; op_a = 32'd100; op_b = 32'd7;
    #1;
    bad = (md_stall !== 1'b0);
    model_op(3'd2, 32'd100, 32'd7);
    tick;
    md_start = 1'b0;
    n = 0;
    while (busy === 1'b1 && n < 40) begin
      n++;
      if (md_stall !== 1'b0) bad = 1'b1;
      tick;
    end
    checks++;
    if (bad || n != 10 || lo !== 32'd14 || hi !== 32'd2) begin
      failures++;
      $display("FAIL stall_idle_d: stalled=%b cycles=%0d hi=%h lo=%h, required 0/10/00000002/0000000e",
               bad, n, hi, lo);
    end
  endtask

  task automatic test_back_to_back;
    int cyc; bit de; bit gl;
    logic [31:0] a;
    logic [31:0] b;
    run_op(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, cyc, de, gl);
    a = $urandom; b = $urandom | 32'd1;
    run_op(3'd2, a, b, 1'b0, cyc, de, gl);
    checks++;
    if (cyc != 10 || de !== 1'b1 || gl || hi !== hi_m || lo !== lo_m) begin
      failures++;
      $display("FAIL back_to_back: cycles=%0d done=%b glitch=%b hi=%h lo=%h, required 10/1/0/%h/%h",
               cyc, de, gl, hi, lo, hi_m, lo_m);
    end
  endtask

  task automatic test_reset_mid;
    int cyc; bit de; bit gl; bit seen;
    run_op(3'd4, 32'h5555AAAA, 32'd0, 1'b0, cyc, de, gl);
    md_start = 1'b1; md_op = 3'd2; op_a = 32'd1000; op_b = 32'd3;
    tick;
    md_start = 1'b0;
    tick; tick;
    reset = 1'b1;
    tick;
    reset = 1'b0;
    hi_m = 32'd0; lo_m = 32'd0;
    checks++;
    if (busy !== 1'b0 || md_done !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
      failures++;
      $display("FAIL reset_mid: busy=%b done=%b hi=%h lo=%h, required 0/0/0/0", busy, md_done, hi, lo);
    end
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (md_done !== 1'b0 || busy !== 1'b0 || hi !== 32'd0) seen = 1'b1;
      tick;
    end
    checks++;
    if (seen) begin
      failures++;
      $display("FAIL reset_mid_after: late activity=%b, required 0", seen);
    end
  endtask

  task automatic test_random;
    int cyc; bit de; bit gl;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom_range(0, 7));
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 5))
        0: b = 32'd0;
        1: begin a = 32'h80000000; b = 32'hFFFFFFFF; end
        2: b = 32'($urandom_range(1, 9));
        default: ;
      endcase
      run_op(op, a, b, ($urandom_range(0, 3) == 0), cyc, de, gl);
      checks++;
      if (cyc != lat(op) || de !== (op <= 3'd3) || gl || hi !== hi_m || lo !== lo_m) begin
        failures++;
        $display("FAIL random[%0d] op=%0d a=%h b=%h: cycles=%0d done=%b glitch=%b hi=%h lo=%h, required %0d/%b/0/%h/%h",
                 i, op, a, b, cyc, de, gl, hi, lo, lat(op), (op <= 3'd3), hi_m, lo_m);
      end
      if ($urandom_range(0, 1) == 1) tick;
    end
  endtask

  initial begin
    test_reset;
    test_mt;
    test_mult;
    test_div;
    test_div_zero;
    test_overflow;
    test_stall;
    test_back_to_back;
    test_reset_mid;
    test_random;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
